r2otfc: RTL and testbench
=========================

Name: r2otfc

Overview:
- Radix-2 on-the-fly converter that sits directly downstream of r2add.
- Consumes the MSDF signed-digit stream s_j, most significant digit first, one digit per clock.
- Accumulates an N-digit fraction without carry propagation, using the Q/QM on-the-fly conversion registers.
- Presents the final two's-complement result with a one-cycle valid pulse, for checking or for conventional-arithmetic consumers.

Parameters:
- N, 8, number of signed digits per operand (fraction digits 2^-1 .. 2^-N).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- s_j  in  2  signed digit, two's complement: 2'b11=-1, 2'b00=0, 2'b01=+1; 2'b10 is illegal.
- d_valid  in  1  s_j carries a digit this cycle.
- d_first  in  1  qualifies d_valid; this digit is the MSD (weight 2^-1) of a new operand.
- q  out  N+1  signed result = sum(d_i * 2^(N-i)), i=1..N, i.e. value * 2^N; range ±(2^N-1).
- q_valid  out  1  one-cycle pulse; q is newly updated.
- busy  out  1  a conversion is in progress (first digit accepted, Nth not yet).
- digit_err  out  1  sticky: an illegal digit was accepted in the current or last operand.

Behaviour:
- Reset (synchronous, clk edge with reset=1): q=0, q_valid=0, busy=0, digit_err=0, Q=0, QM=-1, count=0. Reset wins over every other input that cycle, including mid-operation; the partial operand is discarded.
- Accept condition: d_valid=1 and (d_first=1 or busy=1). Digits with d_valid=1, d_first=0, busy=0 are dropped without any state change.
- d_first=1 (idle or busy): restart.
  - Q and QM are loaded as if from Q=0, QM=-1 with this digit.
  - count=1; busy=1; digit_err is re-evaluated from this digit only.
  - An operand already in progress is abandoned; no q_valid is produced for it.
- Update rule per accepted digit d (N+1-bit registers):
  - d=+1: Q'={Q,1}, QM'={Q,0}.
  - d=0: Q'={Q,0}, QM'={QM,1}.
  - d=-1: Q'={QM,1}, QM'={QM,0}.
  - Implemented as shift-and-select only; no N-bit adder.
  - Invariant: QM = Q-1 at all times.
- Illegal digit 2'b10: treated as 0 and sets digit_err.
- count increments on each accepted digit.
  - On the Nth digit: Q' is written to q on the same edge; q_valid=1 the following cycle (registered); busy=0; count=0.
  - Latency: q_valid is high in the cycle after the edge that accepts digit N.
- d_valid=0 while busy: all state is held; gaps of any length are allowed between digits.
- q holds its last value until the next completed operand. q_valid is high for exactly one cycle.
- A d_first digit accepted on the same edge that q_valid is being raised is legal: back-to-back operands need no idle cycle.
- N=1 is legal: busy never asserts and q_valid follows every d_first digit.

Test Plan (N=4):
- reset=1 for 1 edge with random s_j/d_valid -> q=0, q_valid=0, busy=0, digit_err=0.
- d_first with digits +1,0,-1,+1 on consecutive cycles -> q=5'b00111 (7), q_valid for 1 cycle after the 4th digit, busy high for 3 cycles.
- Digits -1,-1,-1,-1 -> q=5'b10001 (-15). Digits +1,+1,+1,+1 -> q=5'b01111 (15). Digits 0,0,0,0 -> q=0.
- Digits +1,0,-1,+1 with d_valid low for 3 cycles between the 2nd and 3rd digits -> same q=7; q_valid timing shifts by 3 cycles.
- Mid-operand restart: first +1,+1, then d_first with -1,0,0,+1 -> no pulse for the abandoned operand; q=5'b11001 (-7). Same sequence with reset asserted after the 2nd digit -> state cleared, later digits without d_first dropped.
- Illegal digit: +1, 2'b10, 0, 0 -> q=8, digit_err=1. Next operand with legal digits -> digit_err=0.
- Back-to-back: two operands with d_first on cycles 0 and 4 -> two q_valid pulses 4 cycles apart.

Source files
------------

// File: rtl/r2otfc.sv
// r2otfc: radix-2 on-the-fly converter turning an MSDF signed-digit stream into an N+1 bit
// two's-complement result using carry-free Q/QM shift-and-select registers.
module r2otfc #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   s_j,
   input  logic         d_valid,
   input  logic         d_first,
   output logic [N:0]   q,
   output logic         q_valid,
   output logic         busy,
   output logic         digit_err
);
   localparam int CW = $clog2(N + 1);
   // Only the low N bits of Q/QM ever feed a later shift; bit N is pure sign extension.
   logic [N-1:0] qr, qmr, bq, bqm;
   logic [N:0]   q_nxt, qm_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic acc, pos, neg, ill, done;
   always_comb begin
      acc     = d_valid & (d_first | busy);
      pos     = s_j == 2'b01;
      neg     = s_j == 2'b11;
      ill     = s_j == 2'b10;
      bq      = d_first ? '0 : qr;
      bqm     = d_first ? '1 : qmr;
      q_nxt   = neg ? {bqm, 1'b1} : {bq, pos};
      qm_nxt  = pos ? {bq, 1'b0} : {bqm, ~neg};
      cnt_nxt = (d_first ? CW'(0) : cnt) + CW'(1);
      done    = cnt_nxt == CW'(N);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         q         <= '0;
         q_valid   <= 1'b0;
         busy      <= 1'b0;
         digit_err <= 1'b0;
         qr        <= '0;
         qmr       <= '1;
         cnt       <= '0;
      end else begin
         q_valid <= acc & done;
         if (acc) begin
            qr        <= q_nxt[N-1:0];
            qmr       <= qm_nxt[N-1:0];
            busy      <= ~done;
            cnt       <= done ? CW'(0) : cnt_nxt;
            digit_err <= ill | (digit_err & ~d_first);
            if (done) q <= q_nxt;
         end
      end
   end
endmodule

// File: tb/tb_r2otfc.sv
// tb_r2otfc: scoreboard bench for r2otfc at N=4; expected results come from a digit-sum model.
module tb_r2otfc;
   logic clk = 1'b0, reset = 1'b0, d_valid = 1'b0, d_first = 1'b0;
   logic [1:0] s_j = 2'b00;
   logic [4:0] q;
   logic q_valid, busy, digit_err;
   int errors = 0, checks = 0, cyc = 0;
   int busy_cnt, first_cyc, last_cyc;
   logic [4:0] exp_q[$], got_q[$];
   logic exp_e[$], got_e[$];
   int got_c[$];

   r2otfc #(.N(4)) dut (.clk(clk), .reset(reset), .s_j(s_j), .d_valid(d_valid), .d_first(d_first),
                        .q(q), .q_valid(q_valid), .busy(busy), .digit_err(digit_err));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (q_valid === 1'b1) begin
      got_q.push_back(q);
      got_e.push_back(digit_err);
      got_c.push_back(cyc);
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   function automatic int dv(input logic [1:0] c);
      return c == 2'b01 ? 1 : c == 2'b11 ? -1 : 0;
   endfunction

   task automatic drive(input logic [1:0] s, input logic v, input logic f);
      s_j = s; d_valid = v; d_first = f;
      @(posedge clk); #1;
      d_valid = 1'b0; d_first = 1'b0; s_j = 2'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Drives one 4-digit operand (first digit in ds[7:6]) with an optional gap before digit 3.
   task automatic run_op(input logic [7:0] ds, input int gap);
      int e;
      logic er;
      e = 0; er = 1'b0; busy_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         logic [1:0] c;
         c = ds[7-2*i -: 2];
         if (i == 2 && gap > 0) idle(gap);
         drive(c, 1'b1, i == 0);
         if (i == 0) first_cyc = cyc;
         if (busy === 1'b1) busy_cnt++;
         e += dv(c) * (8 >> i);
         er |= (c == 2'b10);
      end
      last_cyc = cyc;
      exp_q.push_back(5'(e));
      exp_e.push_back(er);
   endtask

   task automatic test_reset;
      reset = 1'b1; s_j = 2'($urandom); d_valid = 1'($urandom); d_first = 1'($urandom);
      @(posedge clk); #1;
      reset = 1'b0; d_valid = 1'b0; d_first = 1'b0;
      checks++; if (q !== 5'd0) begin errors++; $display("FAIL reset_q: got %b want 00000", q); end
      checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL reset_q_valid: got %b want 0", q_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (digit_err !== 1'b0) begin errors++; $display("FAIL reset_digit_err: got %b want 0", digit_err); end
      got_q.delete(); got_e.delete(); got_c.delete();
   endtask

   task automatic test_basic;
      run_op(8'b01_00_11_01, 0);
      idle(3);
      checks++; if (busy_cnt !== 3) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 3", busy_cnt); end
      checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL basic_pulse_count: got %0d want 1", got_q.size()); end
      checks++; if (got_c.size() > 0 && got_c[0] !== last_cyc) begin errors++; $display("FAIL basic_latency: got cycle %0d want %0d", got_c[0], last_cyc); end
      while (exp_q.size() > 0) begin
         logic [4:0] eq, gq;
         eq = exp_q.pop_front(); void'(exp_e.pop_front());
         checks++;
         if (got_q.size() == 0) begin errors++; $display("FAIL basic_q: no pulse, want %b", eq); end
         else begin gq = got_q.pop_front(); if (gq !== eq) begin errors++; $display("FAIL basic_q: got %b want %b", gq, eq); end end
      end
      got_q.delete(); got_e.delete(); got_c.delete();
   endtask

   task automatic test_values;
      run_op(8'b11_11_11_11, 0); idle(1);
      run_op(8'b01_01_01_01, 0); idle(1);
      run_op(8'b00_00_00_00, 0); idle(2);
      checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL values_pulse_count: got %0d want 3", got_q.size()); end
      while (exp_q.size() > 0) begin
         logic [4:0] eq, gq;
         eq = exp_q.pop_front(); void'(exp_e.pop_front());
         checks++;
         if (got_q.size() == 0) begin errors++; $display("FAIL values_q: no pulse, want %b", eq); end
         else begin gq = got_q.pop_front(); if (gq !== eq) begin errors++; $display("FAIL values_q: got %b want %b", gq, eq); end end
      end
      got_q.delete(); got_e.delete(); got_c.delete();
   endtask

   task automatic test_gap;
      run_op(8'b01_00_11_01, 3);
      idle(3);
      checks++; if (got_c.size() > 0 && got_c[0] - first_cyc !== 6) begin errors++; $display("FAIL gap_latency: got %0d want 6", got_c[0] - first_cyc); end
      while (exp_q.size() > 0) begin
         logic [4:0] eq, gq;
         eq = exp_q.pop_front(); void'(exp_e.pop_front());
         checks++;
         if (got_q.size() == 0) begin errors++; $display("FAIL gap_q: no pulse, want %b", eq); end
         else begin gq = got_q.pop_front(); if (gq !== eq) begin errors++; $display("FAIL gap_q: got %b want %b", gq, eq); end end
      end
      got_q.delete(); got_e.delete(); got_c.delete();
   endtask

   task automatic test_restart;
      drive(2'b01, 1'b1, 1'b1);
      drive(2'b01, 1'b1, 1'b0);
      run_op(8'b11_00_00_01, 0);
      idle(3);
      checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL restart_pulse_count: got %0d want 1", got_q.size()); end
      while (exp_q.size() > 0) begin
         logic [4:0] eq, gq;
         eq = exp_q.pop_front(); void'(exp_e.pop_front());
         checks++;
         if (got_q.size() == 0) begin errors++; $display("FAIL restart_q: no pulse, want %b", eq); end
         else begin gq = got_q.pop_front(); if (gq !== eq) begin errors++; $display("FAIL restart_q: got %b want %b", gq, eq); end end
      end
      got_q.delete(); got_e.delete(); got_c.delete();
      drive(2'b01, 1'b1, 1'b1);
      drive(2'b01, 1'b1, 1'b0);
      reset = 1'b1;
      drive(2'b01, 1'b1, 1'b1);
      reset = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
      drive(2'b11, 1'b1, 1'b0);
      drive(2'b00, 1'b1, 1'b0);
      drive(2'b00, 1'b1, 1'b0);
      drive(2'b01, 1'b1, 1'b0);
      idle(3);
      checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL reset_mid_pulse_count: got %0d want 0", got_q.size()); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_dropped_busy: got %b want 0", busy); end
      checks++; if (q !== 5'd0) begin errors++; $display("FAIL reset_mid_q: got %b want 00000", q); end
      got_q.delete(); got_e.delete(); got_c.delete();
   endtask

   task automatic test_illegal;
      run_op(8'b01_10_00_00, 0); idle(2);
      run_op(8'b01_11_01_00, 0); idle(2);
      checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL illegal_pulse_count: got %0d want 2", got_q.size()); end
      while (exp_q.size() > 0) begin
         logic [4:0] eq, gq;
         logic ee, ge;
         eq = exp_q.pop_front(); ee = exp_e.pop_front();
         checks++;
         if (got_q.size() == 0) begin errors++; $display("FAIL illegal_q: no pulse, want %b", eq); end
         else begin
            gq = got_q.pop_front(); ge = got_e.pop_front();
            if (gq !== eq) begin errors++; $display("FAIL illegal_q: got %b want %b", gq, eq); end
            checks++;
            if (ge !== ee) begin errors++; $display("FAIL illegal_digit_err: got %b want %b", ge, ee); end
         end
      end
      got_q.delete(); got_e.delete(); got_c.delete();
   endtask

   task automatic test_back_to_back;
      run_op(8'b01_01_00_11, 0);
      run_op(8'b11_01_00_00, 0);
      idle(3);
      checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL b2b_pulse_count: got %0d want 2", got_q.size()); end
      checks++; if (got_c.size() >= 2 && got_c[1] - got_c[0] !== 4) begin errors++; $display("FAIL b2b_spacing: got %0d want 4", got_c[1] - got_c[0]); end
      while (exp_q.size() > 0) begin
         logic [4:0] eq, gq;
         eq = exp_q.pop_front(); void'(exp_e.pop_front());
         checks++;
         if (got_q.size() == 0) begin errors++; $display("FAIL b2b_q: no pulse, want %b", eq); end
         else begin gq = got_q.pop_front(); if (gq !== eq) begin errors++; $display("FAIL b2b_q: got %b want %b", gq, eq); end end
      end
      got_q.delete(); got_e.delete(); got_c.delete();
   endtask

   initial begin
      test_reset;
      test_basic;
      test_values;
      test_gap;
      test_restart;
      test_illegal;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
